// File: rtl/nf10_oq_read_scheduler_if.sv
// Read-request / read-completion channel between the output-queue read
// scheduler (master) and the shared SRAM read engine (slave).
//
// Handshake: rd_req_valid/rd_req_qid are driven by the master and, once
// valid is high, stay stable until the cycle where rd_req_ready is also high;
// that cycle transfers the request. valid is never withdrawn before transfer.
// ready may be asserted regardless of valid. rd_done is a one-cycle pulse from
// the slave with rd_done_qid naming the queue whose packet read completed; it
// has no back-pressure.
interface nf10_oq_read_scheduler_if #(
    parameter int QID_WIDTH = 3
) ();
    logic                 rd_req_valid;
    logic [QID_WIDTH-1:0] rd_req_qid;
    logic                 rd_req_ready;
    logic                 rd_done;
    logic [QID_WIDTH-1:0] rd_done_qid;

    modport master (
        output rd_req_valid,
        output rd_req_qid,
        input  rd_req_ready,
        input  rd_done,
        input  rd_done_qid
    );

    modport slave (
        input  rd_req_valid,
        input  rd_req_qid,
        output rd_req_ready,
        output rd_done,
        output rd_done_qid
    );
endinterface

// File: rtl/nf10_oq_read_scheduler.sv
// Round-robin read scheduler for the SRAM output-queue datapath. Picks the next
// queue for the shared read engine from packet availability, TX space and the
// per-queue in-flight mask, and keeps grant counters plus sticky error flags
// for the register bank. dbg_state exposes the FSM state for observation.
module nf10_oq_read_scheduler #(
    parameter int NUM_QUEUES      = 5,
    parameter int QID_WIDTH       = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNTR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                             axi_aclk,
    input  logic                             axi_resetn,
    input  logic                             sched_enable,
    input  logic [NUM_QUEUES-1:0]            pkt_avail,
    input  logic [NUM_QUEUES-1:0]            tx_space_ok,
    nf10_oq_read_scheduler_if.master         rd_if,
    input  logic                             rst_cntrs,
    output logic [NUM_QUEUES*CNTR_WIDTH-1:0] grant_cnt,
    output logic [2:0]                       outstanding,
    output logic                             timeout_err,
    output logic                             spurious_err,
    output logic                             dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [2:0]  MAX_OUT  = 3'(MAX_OUTSTANDING);

    state_t                state, state_nxt;
    logic [QID_WIDTH-1:0]  rr_ptr;
    logic [QID_WIDTH-1:0]  qid_r;
    logic [QID_WIDTH-1:0]  winner;
    logic                  any_elig;
    logic [NUM_QUEUES-1:0] busy, busy_nxt;
    logic [NUM_QUEUES-1:0] eligible;
    logic                  start;
    logic                  hs;
    logic                  done_hit;
    logic                  done_spur;
    logic [15:0]           wd_cnt;
    logic [CNTR_WIDTH-1:0] cnt_q [NUM_QUEUES];

    // A queue already holding an in-flight read is skipped so its packets stay in order.
    assign eligible = pkt_avail & tx_space_ok & ~busy;

    assign hs    = (state == S_REQ) && rd_if.rd_req_ready;
    assign start = (state == S_IDLE) && sched_enable && any_elig && (outstanding < MAX_OUT);

    assign rd_if.rd_req_valid = (state == S_REQ);
    assign rd_if.rd_req_qid   = qid_r;
    assign dbg_state          = state;

    // Round-robin search: first pass above the pointer, second pass wraps to 0..pointer.
    always_comb begin
        winner   = '0;
        any_elig = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!any_elig && (q > int'(rr_ptr)) && eligible[q]) begin
                any_elig = 1'b1;
                winner   = QID_WIDTH'(q);
            end
        end
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!any_elig && (q <= int'(rr_ptr)) && eligible[q]) begin
                any_elig = 1'b1;
                winner   = QID_WIDTH'(q);
            end
        end
    end

    // Next-state logic: IDLE launches a request, REQ holds it until accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_REQ;
            S_REQ:   if (hs)    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // Request queue id is captured on IDLE->REQ and held; pointer moves on acceptance.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            qid_r  <= '0;
            rr_ptr <= QID_WIDTH'(NUM_QUEUES - 1);
        end else begin
            if (start) qid_r  <= winner;
            if (hs)    rr_ptr <= qid_r;
        end
    end

    // Classify a completion: valid only if it names a queue with a read in flight.
    always_comb begin
        done_hit = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (rd_if.rd_done && (rd_if.rd_done_qid == QID_WIDTH'(q)) && busy[q]) done_hit = 1'b1;
        end
        done_spur = rd_if.rd_done && !done_hit;
    end

    // Busy mask update: clear on completion first, so a same-queue grant ends set.
    always_comb begin
        busy_nxt = busy;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (done_hit && (rd_if.rd_done_qid == QID_WIDTH'(q))) busy_nxt[q] = 1'b0;
            if (hs && (qid_r == QID_WIDTH'(q)))                   busy_nxt[q] = 1'b1;
        end
    end

    // In-flight tracking: busy mask and outstanding count.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            busy        <= '0;
            outstanding <= 3'd0;
        end else begin
            busy <= busy_nxt;
            case ({hs, done_hit})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Per-queue grant counters, wrapping; rst_cntrs wins over an increment.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            for (int q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (rst_cntrs)                            cnt_q[q] <= '0;
                else if (hs && (qid_r == QID_WIDTH'(q)))  cnt_q[q] <= cnt_q[q] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt_pack
        assign grant_cnt[g*CNTR_WIDTH +: CNTR_WIDTH] = cnt_q[g];
    end

    // Watchdog: counts cycles without a completion while reads are in flight.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wd_cnt      <= 16'd0;
            timeout_err <= 1'b0;
        end else if (rst_cntrs) begin
            wd_cnt      <= 16'd0;
            timeout_err <= 1'b0;
        end else if ((outstanding == 3'd0) || rd_if.rd_done) begin
            wd_cnt <= 16'd0;
        end else begin
            if (wd_cnt != WD_LIMIT)          wd_cnt      <= wd_cnt + 16'd1;
            if (wd_cnt >= WD_LIMIT - 16'd1)  timeout_err <= 1'b1;
        end
    end

    // Sticky flag for completions that match no in-flight read.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn)    spurious_err <= 1'b0;
        else if (rst_cntrs) spurious_err <= 1'b0;
        else if (done_spur) spurious_err <= 1'b1;
    end

endmodule

// File: tb/tb_nf10_oq_read_scheduler.sv
// Self-checking bench for nf10_oq_read_scheduler: expected grant order is queued
// when stimulus is set up and compared as each request handshake is observed.
module tb_nf10_oq_read_scheduler;

    localparam int NQ   = 5;
    localparam int QW   = 3;
    localparam int MAXO = 2;
    localparam int CW   = 32;
    localparam int TO   = 20;
    localparam int W    = QW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              sched_enable;
    logic [NQ-1:0]     pkt_avail;
    logic [NQ-1:0]     tx_space_ok;
    logic              rst_cntrs;
    logic [NQ*CW-1:0]  grant_cnt;
    logic [2:0]        outstanding;
    logic              timeout_err;
    logic              spurious_err;
    logic              dbg_state;

    nf10_oq_read_scheduler_if #(.QID_WIDTH(QW)) rif ();

    nf10_oq_read_scheduler #(
        .NUM_QUEUES(NQ), .QID_WIDTH(QW), .MAX_OUTSTANDING(MAXO),
        .CNTR_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_aclk    (clk),
        .axi_resetn  (rst_n),
        .sched_enable(sched_enable),
        .pkt_avail   (pkt_avail),
        .tx_space_ok (tx_space_ok),
        .rd_if       (rif.master),
        .rst_cntrs   (rst_cntrs),
        .grant_cnt   (grant_cnt),
        .outstanding (outstanding),
        .timeout_err (timeout_err),
        .spurious_err(spurious_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int              vectors     = 0;
    int              miscompares = 0;
    int              cyc         = 0;
    int              hs_edge     = 0;
    bit              auto_done   = 1'b0;
    logic [W-1:0]    exp_q[$];
    logic [QW-1:0]   pend_qid[$];
    int              pend_t[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int q);
        return grant_cnt[q*CW +: CW];
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: sample a handshake at the falling edge, then drive after the rising edge.
    task automatic tick();
        logic [W-1:0] e;
        bit           hs_flag;
        int           dummy;
        hs_flag = 1'b0;
        @(negedge clk);
        if (rif.rd_req_valid && rif.rd_req_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("grant_qid", {1'b0, rif.rd_req_qid}, e);
            hs_flag = 1'b1;
            if (auto_done) begin
                pend_qid.push_back(rif.rd_req_qid);
                pend_t.push_back(cyc + 1 + 3);
            end
        end
        @(posedge clk);
        #2;
        cyc++;
        if (hs_flag) hs_edge = cyc;
        if (auto_done) begin
            if (pend_t.size() > 0 && cyc >= pend_t[0]) begin
                rif.rd_done     = 1'b1;
                rif.rd_done_qid = pend_qid.pop_front();
                dummy           = pend_t.pop_front();
            end else begin
                rif.rd_done = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        sched_enable     = 1'b0;
        pkt_avail        = '0;
        tx_space_ok      = '1;
        rst_cntrs        = 1'b0;
        rif.rd_req_ready = 1'b0;
        rif.rd_done      = 1'b0;
        rif.rd_done_qid  = '0;
        auto_done        = 1'b0;
        exp_q.delete();
        pend_qid.delete();
        pend_t.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(input string tag, input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (pend_qid.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", pend_qid.size(), 0);
        tick();
        tick();
    endtask

    task automatic pulse_done(input logic [QW-1:0] q);
        rif.rd_done     = 1'b1;
        rif.rd_done_qid = q;
        tick();
        rif.rd_done     = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int first;
        int n;

        // Reset values (checked while reset is held).
        rst_n = 1'b0;
        #12;
        check("rst_valid", rif.rd_req_valid, 0);
        check("rst_qid", rif.rd_req_qid, 0);
        check("rst_out", outstanding, 0);
        check("rst_errs", {timeout_err, spurious_err}, 0);
        check("rst_cnt", grant_cnt, 0);
        check("rst_state", dbg_state, 0);

        // Round robin over queues 0,2,4 with completions 3 cycles after each grant.
        do_reset();
        pkt_avail        = 5'b10101;
        rif.rd_req_ready = 1'b1;
        auto_done        = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(W'(0));
            exp_q.push_back(W'(2));
            exp_q.push_back(W'(4));
        end
        sched_enable = 1'b1;
        wait_grants("rr_wait", 200);
        sched_enable = 1'b0;
        drain(50);
        check("rr_cnt0", cnt_of(0), 2);
        check("rr_cnt2", cnt_of(2), 2);
        check("rr_cnt4", cnt_of(4), 2);
        check("rr_cnt1", cnt_of(1), 0);
        check("rr_out", outstanding, 0);

        // Valid held stable under back-pressure while pkt_avail drops.
        do_reset();
        pkt_avail    = 5'b00010;
        auto_done    = 1'b1;
        sched_enable = 1'b1;
        tick();
        check("lat_valid", rif.rd_req_valid, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pkt_avail = '0;
            tick();
            check("hold_valid", rif.rd_req_valid, 1);
            check("hold_qid", rif.rd_req_qid, 1);
        end
        exp_q.push_back(W'(1));
        rif.rd_req_ready = 1'b1;
        wait_grants("hold_wait", 5);
        sched_enable = 1'b0;
        drain(20);
        check("hold_cnt1", cnt_of(1), 1);

        // Outstanding limit, then a completion frees a slot.
        do_reset();
        pkt_avail        = 5'b01111;
        rif.rd_req_ready = 1'b1;
        exp_q.push_back(W'(0));
        exp_q.push_back(W'(1));
        sched_enable = 1'b1;
        wait_grants("lim_wait", 20);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("lim_valid", rif.rd_req_valid, 0);
        end
        check("lim_out", outstanding, MAXO);
        exp_q.push_back(W'(2));
        pulse_done(3'd0);
        wait_grants("lim_next", 20);
        check("lim_out2", outstanding, 2);
        check("lim_cnt2", cnt_of(2), 1);

        // Handshake and completion of a different busy queue on the same edge.
        rif.rd_req_ready = 1'b0;
        pulse_done(3'd1);
        exp_q.push_back(W'(3));
        n = 0;
        while (!rif.rd_req_valid && n < 10) begin
            tick();
            n++;
        end
        check("sim_valid", rif.rd_req_valid, 1);
        rif.rd_req_ready = 1'b1;
        rif.rd_done      = 1'b1;
        rif.rd_done_qid  = 3'd2;
        tick();
        rif.rd_done      = 1'b0;
        rif.rd_req_ready = 1'b0;
        check("sim_sb", exp_q.size(), 0);
        check("sim_out", outstanding, 1);
        check("sim_spur", spurious_err, 0);
        pkt_avail = 5'b01100;
        exp_q.push_back(W'(2));
        rif.rd_req_ready = 1'b1;
        wait_grants("sim_next", 20);
        check("sim_out2", outstanding, 2);
        sched_enable = 1'b0;

        // Spurious completions and counter clear.
        do_reset();
        pkt_avail        = 5'b00001;
        rif.rd_req_ready = 1'b1;
        auto_done        = 1'b1;
        exp_q.push_back(W'(0));
        sched_enable = 1'b1;
        wait_grants("spu_wait", 20);
        sched_enable = 1'b0;
        drain(20);
        auto_done = 1'b0;
        check("spu_cnt0", cnt_of(0), 1);
        pulse_done(3'd3);
        check("spu_set", spurious_err, 1);
        check("spu_out", outstanding, 0);
        rst_cntrs = 1'b1;
        tick();
        rst_cntrs = 1'b0;
        check("clr_spur", spurious_err, 0);
        check("clr_cnt", grant_cnt, 0);
        pulse_done(3'd6);
        check("spu_range", spurious_err, 1);
        rst_cntrs = 1'b1;
        tick();
        rst_cntrs = 1'b0;
        check("clr_spur2", spurious_err, 0);

        // Watchdog: flag sets exactly TO cycles after the handshake edge.
        do_reset();
        pkt_avail        = 5'b00001;
        rif.rd_req_ready = 1'b1;
        exp_q.push_back(W'(0));
        sched_enable = 1'b1;
        wait_grants("wd_wait", 20);
        sched_enable = 1'b0;
        check("wd_early", timeout_err, 0);
        first = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (first < 0 && timeout_err) first = cyc;
        end
        check("wd_cycle", 64'(first - hs_edge), TO);
        check("wd_sticky", timeout_err, 1);

        // Asynchronous reset in the middle of a held request.
        pkt_avail        = 5'b00010;
        rif.rd_req_ready = 1'b0;
        sched_enable     = 1'b1;
        tick();
        tick();
        check("ar_pre", {rif.rd_req_valid, rif.rd_req_qid}, 4'b1001);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", rif.rd_req_valid, 0);
        check("ar_qid", rif.rd_req_qid, 0);
        check("ar_out", outstanding, 0);
        check("ar_errs", {timeout_err, spurious_err}, 0);
        check("ar_cnt", grant_cnt, 0);
        check("ar_state", dbg_state, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
